// File: rtl/ft245_tx_arbiter.sv
// ft245_tx_arbiter: packet-level round-robin arbiter for the FT245 TX byte channel.
// One source owns the channel from grant until its last byte is acked or it stalls.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   src_data          byte of source i on [8i+7:8i]
//   src_rdy           source i holds a valid byte until acked
//   src_last          current byte of source i ends its packet
//   src_ack           one-cycle consume pulse toward source i
//   tx_data_si        byte toward the FT245 interface
//   tx_rdy_si         byte valid toward the FT245 interface
//   tx_ack_si         consume pulse from the FT245 interface
//   grant             one-hot channel owner, zero when idle
//   busy              a grant is held
//   timeout_err       one-cycle pulse when a stalled source is reclaimed
//   timeout_src       index of the most recently reclaimed source
module ft245_tx_arbiter #(
  parameter int N_SRC    = 4,
  parameter int MAX_IDLE = 255,
  parameter int SW       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_SRC-1:0] src_data,
  input  logic [N_SRC-1:0]   src_rdy,
  input  logic [N_SRC-1:0]   src_last,
  output logic [N_SRC-1:0]   src_ack,
  output logic [7:0]         tx_data_si,
  output logic               tx_rdy_si,
  input  logic               tx_ack_si,
  output logic [N_SRC-1:0]   grant,
  output logic               busy,
  output logic               timeout_err,
  output logic [SW-1:0]      timeout_src
);

  localparam int CW = $clog2(MAX_IDLE) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [SW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             terr_q, terr_d;
  logic [SW-1:0]    tsrc_q, tsrc_d;

  logic [SW-1:0]    g_idx;
  logic             g_rdy;
  logic             g_last;
  logic [7:0]       g_data;
  logic [SW-1:0]    nxt_ptr;
  logic [SW-1:0]    pick_idx;
  logic             pick_vld;

  // Owner view: everything the datapath needs from the granted source.
  // grant_q is one-hot or zero, so the OR-style loop is a clean mux.
  always_comb begin
    g_idx  = '0;
    g_rdy  = 1'b0;
    g_last = 1'b0;
    g_data = 8'h00;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q[i]) begin
        g_idx  = SW'(i);
        g_rdy  = src_rdy[i];
        g_last = src_last[i];
        g_data = src_data[8*i +: 8];
      end
    end
  end

  // Pointer moves just past the owner whenever the channel is released.
  always_comb begin
    nxt_ptr = '0;
    if (int'(g_idx) != N_SRC - 1) begin
      nxt_ptr = g_idx + SW'(1);
    end
  end

  // Round-robin search from ptr; walking offsets high to low lets the
  // smallest offset from ptr overwrite the others and win.
  always_comb begin
    int j;
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = 0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= N_SRC) begin
        j = j - N_SRC;
      end
      if (src_rdy[j]) begin
        pick_vld = 1'b1;
        pick_idx = SW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    terr_d  = 1'b0;
    tsrc_d  = tsrc_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d           = BUSY;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          cnt_d             = '0;
        end
      end
      BUSY: begin
        // Ack outranks the stall check, so an ack on the
        // final stall cycle keeps the packet alive.
        if (tx_ack_si && g_last) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = nxt_ptr;
          cnt_d   = '0;
        end else if (tx_ack_si || g_rdy) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(MAX_IDLE - 1)) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = nxt_ptr;
          cnt_d   = '0;
          terr_d  = 1'b1;
          tsrc_d  = g_idx;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
      tsrc_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
      tsrc_q  <= tsrc_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q == BUSY);
  assign tx_data_si  = g_data;
  assign tx_rdy_si   = busy & g_rdy;
  assign src_ack     = {N_SRC{tx_ack_si}} & grant_q;
  assign timeout_err = terr_q;
  assign timeout_src = tsrc_q;

endmodule
